uart_tx_arb: RTL and testbench

//  Shares one UART transmitter between NUM_REQ requesters (CPU, debug, DMA, ...).

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rr_pick.sv | 31 +++
 rtl/uart_tx_arb.sv | 133 +++++++++++++
 tb/tb_uart_tx_arb.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the UART transmit arbiter
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_TAG  = 2'd1,
        ARB_XFER = 2'd2
    } arb_state_t;

    localparam logic [7:0] ARB_TAG_BASE = 8'hF0;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker, searching from ptr+1 upward modulo NUM_REQ
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] pos;

    // Walk from the farthest distance down to 1 so the nearest requester overwrites the result.
    always_comb begin
        any = 1'b0;
        idx = '0;
        pos = '0;
        for (int d = NUM_REQ; d >= 1; d--) begin
            pos = IDW'((int'(ptr) + d) % NUM_REQ);
            if (req[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin burst arbiter in front of uart_tx; UART_ARB_TAG_EN adds a tag word per burst
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WORD_WIDTH = 8,
`ifdef UART_ARB_TAG_EN
    parameter int LOCK_MAX   = 16,
    parameter logic [WORD_WIDTH-1:0] TAG_BASE = WORD_WIDTH'(ARB_TAG_BASE)
`else
    parameter int LOCK_MAX   = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [WORD_WIDTH-1:0]         tx_data,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(LOCK_MAX + 1);

    arb_state_t      state_q, state_d;
    logic [IDW-1:0]  rr_ptr, rr_d;
    logic [IDW-1:0]  grant_d;
    logic [CW-1:0]   cnt, cnt_d;

    logic            pick_any;
    logic [IDW-1:0]  pick_idx;

    logic                  lane_valid;
    logic                  lane_last;
    logic [WORD_WIDTH-1:0] lane_data;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        lane_valid = 1'b0;
        lane_last  = 1'b0;
        lane_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                lane_valid = req_valid[i];
                lane_last  = req_last[i];
                lane_data  = req_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr   <= IDW'(NUM_REQ - 1);
            cnt      <= '0;
            grant_id <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr   <= rr_d;
            cnt      <= cnt_d;
            grant_id <= grant_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_ptr;
        cnt_d     = cnt;
        grant_d   = grant_id;
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
`ifdef UART_ARB_TAG_EN
                    state_d = ARB_TAG;
`else
                    state_d = ARB_XFER;
`endif
                end
            end
            ARB_TAG: begin
`ifdef UART_ARB_TAG_EN
                tx_valid = 1'b1;
                tx_data  = TAG_BASE | WORD_WIDTH'(grant_id);
                if (tx_ready) begin
                    state_d = ARB_XFER;
                end
`else
                state_d = ARB_IDLE;
`endif
            end
            ARB_XFER: begin
                tx_valid = lane_valid;
                tx_data  = lane_data;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_id == IDW'(i)) begin
                        req_ready[i] = tx_ready;
                    end
                end
                // A stalled granted lane keeps the grant; only a transfer can end the burst.
                if (lane_valid && tx_ready) begin
                    if (lane_last || (cnt == CW'(LOCK_MAX - 1))) begin
                        rr_d    = grant_id;
                        state_d = ARB_IDLE;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign busy = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed self-checking bench for uart_tx_arb (also covers UART_ARB_TAG_EN builds)
module tb_uart_tx_arb;

`ifdef UART_ARB_TAG_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic [1:0]  grant_id;

    uart_tx_arb #(
        .NUM_REQ    (4),
        .WORD_WIDTH (8),
        .LOCK_MAX   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit inv_en   = 0;
    bit rand_ready = 0;

    logic [7:0] qd [4][$];
    bit         ql [4][$];
    logic [7:0] log_d [$];
    logic [1:0] log_g [$];
    int         log_c [$];
    logic [7:0] tag_d [$];
    logic [7:0] exp_d [$];
    logic [1:0] exp_g [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (qd[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = qd[i][0];
                req_last[i]        = ql[i][0];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit l);
        qd[r].push_back(d);
        ql[r].push_back(l);
    endtask

    task automatic step();
        logic [3:0] pop;
        bit         hold;
        logic [7:0] hold_data;
        pop = rst ? 4'b0000 : (req_valid & req_ready);
        if (!rst && tx_valid === 1'b1 && tx_ready) begin
            if (|req_ready) begin
                log_d.push_back(tx_data);
                log_g.push_back(grant_id);
                log_c.push_back(cyc);
            end else begin
                tag_d.push_back(tx_data);
            end
        end
        hold      = !rst && (tx_valid === 1'b1) && !tx_ready;
        hold_data = tx_data;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (pop[i]) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
            end
        end
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
        drive();
        #1;
        if (inv_en && !rst) begin
            if (hold) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, hold_data);
            end
            chk("ready_other_lanes", req_ready & ~(4'b0001 << grant_id), 0);
            if (!busy) chk("idle_quiet", {tx_valid, req_ready}, 0);
`ifndef UART_ARB_TAG_EN
            if (busy) chk("ready_follows_tx", req_ready[grant_id], tx_ready);
`endif
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rand_ready = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            qd[i].delete();
            ql[i].delete();
        end
        drive();
        step();
        step();
        rst = 1'b0;
        log_d.delete(); log_g.delete(); log_c.delete(); tag_d.delete();
        exp_d.delete(); exp_g.delete();
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((qd[0].size() + qd[1].size() + qd[2].size() + qd[3].size() > 0 || busy) && n < max) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < max, 1);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, log_d.size(), exp_d.size());
        for (int n = 0; n < exp_d.size() && n < log_d.size(); n++) begin
            chk({tag, "_data"}, log_d[n], exp_d[n]);
            chk({tag, "_gid"}, log_g[n], exp_g[n]);
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_ready = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0;

        // Reset with every requester asking; req 0 must win first.
        for (int i = 0; i < 4; i++) push(i, 8'(8'hA0 + i), 1'b1);
        drive();
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_tx_data", tx_data, 0);
        rst = 1'b0;
        inv_en = 1;
        step();
        chk("first_busy", busy, 1);
        chk("first_grant", grant_id, 0);
        drain(200);
        for (int i = 0; i < 4; i++) begin
            exp_d.push_back(8'(8'hA0 + i));
            exp_g.push_back(2'(i));
        end
        check_log("rst_order");

        // Two bursts, then a single requester sending back-to-back bursts.
        do_reset();
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b1); push(2, 8'h33, 1'b1);
        drive(); #1;
        drain(200);
        exp_d = '{8'h11, 8'h22, 8'h33};
        exp_g = '{2'd0, 2'd0, 2'd2};
        check_log("burst");
        if (log_c.size() == 3) begin
            chk("burst_back_to_back", log_c[1] - log_c[0], 1);
            chk("burst_gap", log_c[2] - log_c[1], GAP);
        end
        log_d.delete(); log_g.delete(); log_c.delete();
        push(1, 8'h44, 1'b1); push(1, 8'h55, 1'b1);
        drive(); #1;
        drain(200);
        exp_d = '{8'h44, 8'h55};
        exp_g = '{2'd1, 2'd1};
        check_log("single");
        if (log_c.size() == 2) chk("single_gap", log_c[1] - log_c[0], GAP);

        // Fairness: 100 single-word bursts across four always-valid requesters.
        do_reset();
        for (int k = 0; k < 25; k++)
            for (int i = 0; i < 4; i++) push(i, 8'((i << 6) | k), 1'b1);
        drive(); #1;
        drain(2000);
        for (int n = 0; n < 100; n++) begin
            exp_d.push_back(8'((((n % 4)) << 6) | (n / 4)));
            exp_g.push_back(2'(n % 4));
        end
        check_log("fair");

        // LOCK_MAX forces re-arbitration of an endless stream.
        do_reset();
        for (int k = 0; k < 40; k++) push(1, 8'(k), 1'b0);
        push(3, 8'hC0, 1'b0); push(3, 8'hC1, 1'b1);
        drive(); #1;
        begin
            int n = 0;
            while (log_d.size() < 42 && n < 1000) begin
                step();
                n++;
            end
            chk("lock_in_budget", n < 1000, 1);
        end
        for (int k = 0; k < 16; k++) begin exp_d.push_back(8'(k)); exp_g.push_back(2'd1); end
        exp_d.push_back(8'hC0); exp_g.push_back(2'd3);
        exp_d.push_back(8'hC1); exp_g.push_back(2'd3);
        for (int k = 16; k < 40; k++) begin exp_d.push_back(8'(k)); exp_g.push_back(2'd1); end
        check_log("lock");
        repeat (3) step();
        chk("stall_busy", busy, 1);
        chk("stall_tx_valid", tx_valid, 0);
        chk("stall_grant", grant_id, 1);

        // Random backpressure; stability is checked every cycle inside step().
        do_reset();
        for (int k = 0; k < 5; k++) push(0, 8'(8'h50 + k), k == 4);
        for (int k = 0; k < 3; k++) push(2, 8'(8'h60 + k), k == 2);
        push(3, 8'h70, 1'b1);
        rand_ready = 1;
        drive(); #1;
        drain(1000);
        rand_ready = 0;
        tx_ready = 1'b1;
        exp_d = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h60, 8'h61, 8'h62, 8'h70};
        exp_g = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd3};
        check_log("bp");

`ifdef UART_ARB_TAG_EN
        do_reset();
        push(2, 8'hAA, 1'b1);
        drive(); #1;
        drain(200);
        chk("tag_count", tag_d.size(), 1);
        if (tag_d.size() > 0) chk("tag_word", tag_d[0], 8'hF2);
        exp_d = '{8'hAA};
        exp_g = '{2'd2};
        check_log("tag_payload");
`endif

        // Reset in the first cycle of a grant aborts it.
        do_reset();
        tx_ready = 1'b0;
        push(1, 8'hBB, 1'b1);
        drive(); #1;
        step();
        chk("pre_abort_valid", tx_valid, 1);
`ifdef UART_ARB_TAG_EN
        chk("pre_abort_data", tx_data, 8'hF1);
`else
        chk("pre_abort_data", tx_data, 8'hBB);
`endif
        rst = 1'b1;
        step();
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_grant", grant_id, 0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
